// File: rtl/xor_multiport_ram.sv
// Multi-ported RAM built from XOR-coded banks: one bank per write port.
// A logical word is the XOR of all banks; a reset-time sweep clears them.
module xor_multiport_ram #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int WR_PORTS   = 2,
    parameter int RD_PORTS   = 2,
    parameter int RD_LATENCY = 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         ready,
    input  logic [WR_PORTS-1:0]          wr_en,
    input  logic [WR_PORTS*AW-1:0]       wr_addr,
    input  logic [WR_PORTS*WIDTH-1:0]    wr_data,
    output logic [WR_PORTS-1:0]          wr_collision,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*AW-1:0]       rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]    rd_data,
    output logic [RD_PORTS-1:0]          rd_valid
);

    localparam logic [0:0]    ST_INIT = 1'b0;
    localparam logic [0:0]    ST_RUN  = 1'b1;
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [0:0]                 state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic [WR_PORTS-1:0]        coll_q, coll_d;
    logic [RD_PORTS-1:0]        rv1_q, rv1_d;
    logic [RD_PORTS*WIDTH-1:0]  rd1_q, rd1_d;
    logic [WIDTH-1:0]           mem_q [WR_PORTS][DEPTH];

    logic                       run;
    logic [WR_PORTS-1:0]        wr_ok, wr_win;
    logic [AW-1:0]              wa [WR_PORTS];
    logic [AW-1:0]              wi [WR_PORTS];
    logic [WIDTH-1:0]           wr_word [WR_PORTS];
    logic [AW-1:0]              ra [RD_PORTS];
    logic [WIDTH-1:0]           rd_word [RD_PORTS];

    assign run   = (state_q == ST_RUN);
    assign ready = run;
    assign wr_collision = coll_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == LAST) state_d = ST_RUN;
            else               cnt_d   = cnt_q + 1'b1;
        end
    end

    // Lowest-index port wins among in-range writes to the same address.
    always_comb begin
        for (int p = 0; p < WR_PORTS; p++) begin
            wa[p]    = wr_addr[p*AW +: AW];
            wr_ok[p] = run && wr_en[p] && (int'(wa[p]) < DEPTH);
            wi[p]    = wr_ok[p] ? wa[p] : '0;
        end
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_win[p] = wr_ok[p];
            for (int q = 0; q < p; q++) begin
                if (wr_ok[q] && (wa[q] == wa[p])) wr_win[p] = 1'b0;
            end
        end
        coll_d = wr_ok & ~wr_win;
        for (int p = 0; p < WR_PORTS; p++) begin
            wr_word[p] = wr_data[p*WIDTH +: WIDTH];
            for (int q = 0; q < WR_PORTS; q++) begin
                if (q != p) wr_word[p] = wr_word[p] ^ mem_q[q][wi[p]];
            end
        end
    end

    always_comb begin
        rv1_d = '0;
        rd1_d = rd1_q;
        for (int r = 0; r < RD_PORTS; r++) begin
            ra[r]      = rd_addr[r*AW +: AW];
            rd_word[r] = '0;
            if (int'(ra[r]) < DEPTH) begin
                for (int q = 0; q < WR_PORTS; q++) begin
                    rd_word[r] = rd_word[r] ^ mem_q[q][ra[r]];
                end
            end
            rv1_d[r] = run && rd_en[r];
            if (rv1_d[r]) rd1_d[r*WIDTH +: WIDTH] = rd_word[r];
        end
    end

    // Banks carry no reset; the INIT sweep zeroes them instead.
    always_ff @(posedge clk) begin
        for (int p = 0; p < WR_PORTS; p++) begin
            if (!run)           mem_q[p][cnt_q] <= '0;
            else if (wr_win[p]) mem_q[p][wi[p]] <= wr_word[p];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            coll_q  <= '0;
            rv1_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            coll_q  <= coll_d;
            rv1_q   <= rv1_d;
            rd1_q   <= rd1_d;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [RD_PORTS-1:0]       rv2_q, rv2_d;
            logic [RD_PORTS*WIDTH-1:0] rd2_q, rd2_d;

            always_comb begin
                rv2_d = rv1_q;
                rd2_d = rd2_q;
                for (int r = 0; r < RD_PORTS; r++) begin
                    if (rv1_q[r]) rd2_d[r*WIDTH +: WIDTH] = rd1_q[r*WIDTH +: WIDTH];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rv2_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rv2_q <= rv2_d;
                    rd2_q <= rd2_d;
                end
            end

            assign rd_valid = rv2_q;
            assign rd_data  = rd2_q;
        end else begin : g_lat1
            assign rd_valid = rv1_q;
            assign rd_data  = rd1_q;
        end
    endgenerate

endmodule

// File: tb/tb_xor_multiport_ram.sv
// Bench for xor_multiport_ram: two instances (1024/lat1, 1000/lat2) share
// stimulus and are checked each cycle against a word-level reference model.
module tb_xor_multiport_ram;

    localparam int W  = 32;
    localparam int WP = 2;
    localparam int RP = 2;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WP-1:0]    wr_en = '0;
    logic [WP*AW-1:0] wr_addr = '0;
    logic [WP*W-1:0]  wr_data = '0;
    logic [RP-1:0]    rd_en = '0;
    logic [RP*AW-1:0] rd_addr = '0;

    logic          rdy0, rdy1;
    logic [WP-1:0] col0, col1;
    logic [RP*W-1:0] rdd0, rdd1;
    logic [RP-1:0] rdv0, rdv1;

    xor_multiport_ram #(.WIDTH(W), .DEPTH(1024), .WR_PORTS(WP),
                        .RD_PORTS(RP), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_collision(col0), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd0), .rd_valid(rdv0)
    );

    xor_multiport_ram #(.WIDTH(W), .DEPTH(1000), .WR_PORTS(WP),
                        .RD_PORTS(RP), .RD_LATENCY(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ready(rdy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_collision(col1), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdd1), .rd_valid(rdv1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: logical words per instance plus an output delay line.
    int          dep [2] = '{1024, 1000};
    int          lat [2] = '{1, 2};
    logic [W-1:0] mem [2][1024];
    int          cnt [2];
    bit          mrdy [2];
    bit          ov [2][RP];
    logic [W-1:0] od [2][RP];
    bit          pv [2][RP];
    logic [W-1:0] pd [2][RP];
    logic [WP-1:0] mcol [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            mrdy[k] = 1'b0;
            mcol[k] = '0;
            for (int a = 0; a < 1024; a++) mem[k][a] = '0;
            for (int r = 0; r < RP; r++) begin
                ov[k][r] = 1'b0; od[k][r] = '0;
                pv[k][r] = 1'b0; pd[k][r] = '0;
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit nv [RP];
            logic [W-1:0] nd [RP];
            mcol[k] = '0;
            for (int r = 0; r < RP; r++) begin
                nv[r] = 1'b0;
                nd[r] = '0;
            end
            if (!mrdy[k]) begin
                if (cnt[k] == dep[k] - 1) mrdy[k] = 1'b1;
                else cnt[k]++;
            end else begin
                for (int r = 0; r < RP; r++) begin
                    int a;
                    a = int'(rd_addr[r*AW +: AW]);
                    nv[r] = rd_en[r];
                    nd[r] = (a < dep[k]) ? mem[k][a] : '0;
                end
                for (int p = 0; p < WP; p++) begin
                    int a;
                    bit lost;
                    a = int'(wr_addr[p*AW +: AW]);
                    lost = 1'b0;
                    if (wr_en[p] && a < dep[k]) begin
                        for (int q = 0; q < p; q++) begin
                            if (wr_en[q] && int'(wr_addr[q*AW +: AW]) == a) lost = 1'b1;
                        end
                        if (lost) mcol[k][p] = 1'b1;
                        else mem[k][a] = wr_data[p*W +: W];
                    end
                end
            end
            for (int r = 0; r < RP; r++) begin
                if (lat[k] == 1) begin
                    ov[k][r] = nv[r];
                    if (nv[r]) od[k][r] = nd[r];
                end else begin
                    ov[k][r] = pv[k][r];
                    if (pv[k][r]) od[k][r] = pd[k][r];
                    pv[k][r] = nv[r];
                    if (nv[r]) pd[k][r] = nd[r];
                end
            end
        end
    endtask

    task automatic compare_all();
        check("dut0.ready", 64'(rdy0), 64'(mrdy[0]));
        check("dut1.ready", 64'(rdy1), 64'(mrdy[1]));
        check("dut0.wr_collision", 64'(col0), 64'(mcol[0]));
        check("dut1.wr_collision", 64'(col1), 64'(mcol[1]));
        check("dut0.rd_valid", 64'(rdv0), 64'({ov[0][1], ov[0][0]}));
        check("dut1.rd_valid", 64'(rdv1), 64'({ov[1][1], ov[1][0]}));
        check("dut0.rd_data", 64'(rdd0), {od[0][1], od[0][0]});
        check("dut1.rd_data", 64'(rdd1), {od[1][1], od[1][0]});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        wr_en = '0;
        rd_en = '0;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 9) < 7) return AW'($urandom_range(0, 15));
        return AW'($urandom_range(990, 1023));
    endfunction

    task automatic rand_inputs();
        wr_en = WP'($urandom);
        rd_en = RP'($urandom);
        for (int p = 0; p < WP; p++) begin
            wr_addr[p*AW +: AW] = pick_addr();
            wr_data[p*W +: W]   = $urandom;
        end
        for (int r = 0; r < RP; r++) rd_addr[r*AW +: AW] = pick_addr();
    endtask

    task automatic run_init();
        int n;
        n = 0;
        rst_n = 1'b1;
        while (!rdy0 && n < 2000) begin
            step();
            n++;
        end
        check("init_len", 64'(n), 64'd1024);
    endtask

    task automatic read_sweep();
        idle();
        for (int a = 0; a < 1024; a++) begin
            rd_en = '1;
            rd_addr = {AW'(1023 - a), AW'(a)};
            step();
        end
        idle();
        step();
        step();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst.ready", 64'({rdy1, rdy0}), 64'd0);
        check("rst.rd_valid", 64'({rdv1, rdv0}), 64'd0);
        check("rst.rd_data0", 64'(rdd0), 64'd0);
        check("rst.rd_data1", 64'(rdd1), 64'd0);
        check("rst.wr_collision", 64'({col1, col0}), 64'd0);
        model_reset();
        idle();
        step();
        step();
    endtask

    initial begin
        model_reset();
        idle();
        #1;
        check("por.ready", 64'({rdy1, rdy0}), 64'd0);
        step();
        step();
        run_init();
        read_sweep();

        wr_en = 2'b11;
        wr_addr = {AW'(9), AW'(5)};
        wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        step();
        check("dir.no_coll", 64'(col0), 64'd0);
        idle();
        rd_en = 2'b11;
        rd_addr = {AW'(9), AW'(5)};
        step();
        check("dir.rd_5_9", 64'(rdd0), {32'h1234_5678, 32'hDEAD_BEEF});
        idle();
        step();
        check("dir.rd_5_9_lat2", 64'(rdd1), {32'h1234_5678, 32'hDEAD_BEEF});

        wr_en = 2'b11;
        wr_addr = {AW'(7), AW'(7)};
        wr_data = {32'h5555_FFFF, 32'hAAAA_0000};
        step();
        check("dir.coll_7", 64'(col0), 64'd2);
        idle();
        rd_en = 2'b01;
        rd_addr = {AW'(0), AW'(7)};
        step();
        check("dir.coll_clear", 64'(col0), 64'd0);
        check("dir.rd_7", 64'(rdd0[31:0]), 64'h0000_0000_AAAA_0000);

        wr_en = 2'b01;
        wr_addr = {AW'(0), AW'(3)};
        wr_data = {32'h0, 32'h1};
        rd_en = '0;
        step();
        wr_data = {32'h0, 32'h2};
        rd_en = 2'b01;
        rd_addr = {AW'(0), AW'(3)};
        step();
        check("dir.rf_old", 64'(rdd0[31:0]), 64'd1);
        wr_en = '0;
        step();
        check("dir.rf_new", 64'(rdd0[31:0]), 64'd2);
        check("dir.rf_old_lat2", 64'(rdd1[31:0]), 64'd1);
        idle();
        step();
        check("dir.rf_new_lat2", 64'(rdd1[31:0]), 64'd2);

        wr_en = 2'b11;
        wr_addr = {AW'(1010), AW'(1010)};
        wr_data = {32'h77, 32'hFF};
        step();
        check("dir.oor_coll", 64'(col1), 64'd0);
        idle();
        rd_en = 2'b11;
        rd_addr = {AW'(999), AW'(1010)};
        step();
        idle();
        step();
        check("dir.oor_rd", 64'(rdd1[31:0]), 64'd0);
        check("dir.oor_valid", 64'(rdv1), 64'd3);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        async_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) step();
        async_reset();
        run_init();
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            step();
        end
        async_reset();
        run_init();
        read_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
